// File: rtl/ten_gig_axis_pkg.sv
// Shared definitions for the 10G Ethernet AXIS test path (generator and checker).
package ten_gig_axis_pkg;

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;

  // Bit positions inside the 4-bit error vector.
  localparam int ERR_DATA = 0;
  localparam int ERR_LEN  = 1;
  localparam int ERR_KEEP = 2;
  localparam int ERR_OVER = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PKT  = 2'd1,
    S_DROP = 2'd2
  } chk_state_e;

  // Test payload for 0-based beat k: the 16-bit value k+1 repeated four times.
  function automatic logic [DATA_W-1:0] pattern_word(input logic [15:0] k);
    logic [15:0] v;
    v = k + 16'd1;
    return {4{v}};
  endfunction

endpackage

// File: rtl/axis_keep_popcnt.sv
// Combinational tkeep helper: byte count and MSB-contiguity of the enable mask.
module axis_keep_popcnt
  import ten_gig_axis_pkg::*;
(
  input  logic [KEEP_W-1:0] keep,
  output logic [3:0]        count,
  output logic              msb_contig
);

  logic [KEEP_W-1:0] inv;

  // Popcount plus contiguity: ~keep must be a run of ones anchored at the LSB.
  // NOTE: every output of a combinational block gets a default before any
  // conditional logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      count = count + {3'b000, keep[i]};
    end
    inv        = ~keep;
    msb_contig = ((inv & (inv + 8'd1)) == 8'd0);
  end

endmodule

// File: rtl/axis_pkt_checker.sv
// Receive-side checker: validates payload pattern, length, tkeep and overlength
// per packet, and keeps saturating packet/error counters and sticky flags.
module axis_pkt_checker
  import ten_gig_axis_pkg::*;
#(
  parameter logic [15:0] P_MAX_BEATS = 16'd256,
  parameter logic [7:0]  P_BP_PERIOD = 8'd4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [31:0]       s_axis_tuser,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              i_bp_en,
  input  logic              i_clr_stats,
  output logic              o_pkt_done,
  output logic              o_pkt_ok,
  output logic [15:0]       o_pkt_len,
  output logic [31:0]       o_pkt_cnt,
  output logic [31:0]       o_err_cnt,
  output logic [3:0]        o_err_flags
);

  chk_state_e        state, state_next;
  logic [15:0]       beat_idx;
  logic [15:0]       byte_cnt;
  logic [15:0]       len_exp;
  logic [3:0]        err_acc;
  logic [7:0]        bp_cnt;

  logic              accept;
  logic              complete;
  logic [3:0]        pop;
  logic              msb_contig;
  logic [DATA_W-1:0] expected;
  logic              data_err;
  logic              keep_err;
  logic              len_chg;
  logic              over_beat;
  logic              dropping;
  logic [16:0]       byte_wide;
  logic [15:0]       byte_sum;
  logic [15:0]       len_ref;
  logic [3:0]        beat_err;
  logic [3:0]        pkt_err;

  // The upper tuser half carries no meaning for this checker.
  logic              tuser_unused;
  assign tuser_unused = ^s_axis_tuser[31:16];

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign complete = accept & s_axis_tlast;

  axis_keep_popcnt u_keep (
    .keep       (s_axis_tkeep),
    .count      (pop),
    .msb_contig (msb_contig)
  );

  // Next state and per-beat error evaluation for the beat currently on the bus.
  always_comb begin
    state_next = state;
    expected   = pattern_word(beat_idx);
    data_err   = 1'b0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != expected[8*i +: 8])) begin
        data_err = 1'b1;
      end
    end
    keep_err  = s_axis_tlast ? ((s_axis_tkeep == '0) || !msb_contig)
                             : (s_axis_tkeep != 8'hFF);
    len_chg   = (state != S_IDLE) && (s_axis_tuser[15:0] != len_exp);
    over_beat = (state == S_PKT) && (beat_idx == P_MAX_BEATS);
    dropping  = (state == S_DROP) || over_beat;

    beat_err           = '0;
    beat_err[ERR_DATA] = data_err & ~dropping;
    beat_err[ERR_LEN]  = len_chg;
    beat_err[ERR_KEEP] = keep_err & ~dropping;
    beat_err[ERR_OVER] = over_beat;

    byte_wide = {1'b0, byte_cnt} + {13'd0, pop};
    byte_sum  = byte_wide[16] ? 16'hFFFF : byte_wide[15:0];
    len_ref   = (state == S_IDLE) ? s_axis_tuser[15:0] : len_exp;

    pkt_err          = err_acc | beat_err;
    pkt_err[ERR_LEN] = pkt_err[ERR_LEN] | (byte_sum != len_ref);

    if (accept) begin
      unique case (state)
        S_IDLE:  state_next = s_axis_tlast ? S_IDLE : S_PKT;
        S_PKT:   state_next = s_axis_tlast ? S_IDLE : (over_beat ? S_DROP : S_PKT);
        S_DROP:  state_next = s_axis_tlast ? S_IDLE : S_DROP;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Per-packet accumulators; cleared when a packet completes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_idx <= '0;
      byte_cnt <= '0;
      len_exp  <= '0;
      err_acc  <= '0;
    end else if (accept) begin
      if (state == S_IDLE) len_exp <= s_axis_tuser[15:0];
      if (complete) begin
        beat_idx <= '0;
        byte_cnt <= '0;
        err_acc  <= '0;
      end else begin
        beat_idx <= dropping ? beat_idx : beat_idx + 16'd1;
        byte_cnt <= byte_sum;
        err_acc  <= err_acc | beat_err;
      end
    end
  end

  // Registered ready with optional one-low-cycle-per-period backpressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bp_cnt        <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      bp_cnt        <= (bp_cnt == P_BP_PERIOD - 8'd1) ? 8'd0 : bp_cnt + 8'd1;
      s_axis_tready <= !(i_bp_en && (bp_cnt == P_BP_PERIOD - 8'd1));
    end
  end

  // Packet result pulse plus statistics; a clear on a completion edge wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pkt_done  <= 1'b0;
      o_pkt_ok    <= 1'b0;
      o_pkt_len   <= '0;
      o_pkt_cnt   <= '0;
      o_err_cnt   <= '0;
      o_err_flags <= '0;
    end else begin
      o_pkt_done <= complete;
      if (complete) begin
        o_pkt_ok  <= (pkt_err == '0);
        o_pkt_len <= byte_sum;
      end
      if (i_clr_stats) begin
        o_pkt_cnt   <= '0;
        o_err_cnt   <= '0;
        o_err_flags <= '0;
      end else if (complete) begin
        if (o_pkt_cnt != 32'hFFFF_FFFF) o_pkt_cnt <= o_pkt_cnt + 32'd1;
        if ((pkt_err != '0) && (o_err_cnt != 32'hFFFF_FFFF)) o_err_cnt <= o_err_cnt + 32'd1;
        o_err_flags <= o_err_flags | pkt_err;
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Self-checking bench for axis_pkt_checker: packet-level reference model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_axis_pkt_checker;

  localparam int MAX_BEATS = 256;
  localparam int MAX_ARR   = 320;

  typedef struct packed {
    logic        ok;
    logic [15:0] len;
    logic [3:0]  flags;
  } res_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [31:0] s_axis_tuser = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        i_bp_en = 1'b0;
  logic        i_clr_stats = 1'b0;
  logic        o_pkt_done;
  logic        o_pkt_ok;
  logic [15:0] o_pkt_len;
  logic [31:0] o_pkt_cnt;
  logic [31:0] o_err_cnt;
  logic [3:0]  o_err_flags;

  int n_cmp = 0;
  int n_bad = 0;

  // Packet under construction.
  logic [63:0] b_data [MAX_ARR];
  logic [7:0]  b_keep [MAX_ARR];
  logic [15:0] b_user [MAX_ARR];
  int          n_beats;

  // Results of packets whose tlast the driver has committed, in order.
  res_t res_arr [64];
  int   n_sent = 0;
  int   n_seen = 0;

  // Reference state advanced on each rising edge.
  bit          started = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ok = 1'b0;
  logic [15:0] m_len = '0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_err = '0;
  logic [3:0]  m_flags = '0;
  logic        m_rdy = 1'b0;
  logic        m_rdy_chk = 1'b0;

  logic        last_ok = 1'b0;
  logic [15:0] last_len = '0;
  int          n_done = 0;

  axis_pkt_checker #(
    .P_MAX_BEATS (16'd256),
    .P_BP_PERIOD (8'd4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .i_bp_en       (i_bp_en),
    .i_clr_stats   (i_clr_stats),
    .o_pkt_done    (o_pkt_done),
    .o_pkt_ok      (o_pkt_ok),
    .o_pkt_len     (o_pkt_len),
    .o_pkt_cnt     (o_pkt_cnt),
    .o_err_cnt     (o_err_cnt),
    .o_err_flags   (o_err_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fill the packet buffer with a correct n-beat packet.
  task automatic build_pkt(input int n, input logic [15:0] user, input logic [7:0] last_keep);
    logic [15:0] kk;
    n_beats = n;
    for (int k = 0; k < n; k++) begin
      kk        = 16'(k + 1);
      b_data[k] = {kk, kk, kk, kk};
      b_keep[k] = (k == n - 1) ? last_keep : 8'hFF;
      b_user[k] = user;
    end
  endtask

  // Expected packet result straight from the checking rules.
  function automatic res_t eval_pkt();
    res_t        r;
    int          bytes;
    logic [15:0] kk;
    logic [63:0] pat;
    r     = '0;
    bytes = 0;
    for (int k = 0; k < n_beats; k++) begin
      bytes += $countones(b_keep[k]);
      if (bytes > 65535) bytes = 65535;
      if (b_user[k] != b_user[0]) r.flags[1] = 1'b1;
      if (k >= MAX_BEATS) begin
        r.flags[3] = 1'b1;
      end else begin
        kk  = 16'(k + 1);
        pat = {kk, kk, kk, kk};
        if (k == n_beats - 1) begin
          if (!(b_keep[k] inside {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF}))
            r.flags[2] = 1'b1;
        end else if (b_keep[k] != 8'hFF) begin
          r.flags[2] = 1'b1;
        end
        for (int j = 0; j < 8; j++) begin
          if (b_keep[k][j] && (b_data[k][8*j +: 8] != pat[8*j +: 8])) r.flags[0] = 1'b1;
        end
      end
    end
    if (bytes != int'(b_user[0])) r.flags[1] = 1'b1;
    r.len = 16'(bytes);
    r.ok  = (r.flags == 4'd0);
    return r;
  endfunction

  // Drive the buffered packet; called and returning on a falling edge.
  task automatic send_pkt(input int abort_at, input bit clr_last);
    res_t r;
    int   guard;
    r = eval_pkt();
    for (int i = 0; i < n_beats; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b_data[i];
      s_axis_tkeep  = b_keep[i];
      s_axis_tuser  = {16'hA5A5, b_user[i]};
      s_axis_tlast  = (i == n_beats - 1);
      if (i == abort_at) begin
        i_rst = 1'b1;
        @(negedge clk);
        i_rst         = 1'b0;
        s_axis_tvalid = 1'b0;
        return;
      end
      guard = 0;
      while (!s_axis_tready && guard < 16) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 16) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tready_wait: tready stayed 0 for %0d cycles, required 1", guard);
        s_axis_tvalid = 1'b0;
        return;
      end
      if (i == n_beats - 1) begin
        res_arr[n_sent] = r;
        n_sent++;
        if (clr_last) i_clr_stats = 1'b1;
      end
      @(negedge clk);
      i_clr_stats = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Reference model: consumes committed packet results and tracks statistics.
  always @(posedge clk) begin
    res_t r;
    started   = 1'b1;
    m_done    = 1'b0;
    m_rdy     = !i_rst;
    m_rdy_chk = !i_bp_en;
    if (i_rst) begin
      m_cnt   = '0;
      m_err   = '0;
      m_flags = '0;
    end else begin
      if (n_seen != n_sent) begin
        r      = res_arr[n_seen];
        n_seen = n_seen + 1;
        m_done = 1'b1;
        m_ok   = r.ok;
        m_len  = r.len;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (r.flags != 4'd0 && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
        m_flags = m_flags | r.flags;
      end
      if (i_clr_stats) begin
        m_cnt   = '0;
        m_err   = '0;
        m_flags = '0;
      end
    end
  end

  // Compare process: every falling edge once the model is running.
  always @(negedge clk) begin
    if (started) begin
      check("pkt_done", o_pkt_done, m_done);
      if (m_done) begin
        check("pkt_ok", o_pkt_ok, m_ok);
        check("pkt_len", o_pkt_len, m_len);
      end
      if (o_pkt_done) begin
        last_ok  = o_pkt_ok;
        last_len = o_pkt_len;
        n_done   = n_done + 1;
      end
      check("pkt_cnt", o_pkt_cnt, m_cnt);
      check("err_cnt", o_err_cnt, m_err);
      check("err_flags", o_err_flags, m_flags);
      if (m_rdy_chk) check("tready", s_axis_tready, m_rdy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rs;
    logic [7:0] rs_exp;
    int         z;
    int         done_base;

    // Reset state.
    idle(2);
    check("rst_tready", s_axis_tready, 0);
    check("rst_done", o_pkt_done, 0);
    check("rst_ok", o_pkt_ok, 0);
    check("rst_len", o_pkt_len, 0);
    check("rst_cnt", o_pkt_cnt, 0);
    check("rst_flags", o_err_flags, 0);
    i_rst = 1'b0;
    idle(2);

    // Happy path.
    build_pkt(16, 16'd128, 8'hFF);
    send_pkt(-1, 1'b0);
    idle(1);
    check("happy_ok", last_ok, 1);
    check("happy_len", last_len, 128);
    check("happy_cnt", o_pkt_cnt, 1);
    check("happy_flags", o_err_flags, 0);

    // Eight back-to-back packets, 121..128 bytes.
    for (int p = 1; p <= 8; p++) begin
      build_pkt(16, 16'(120 + p), ~(8'hFF >> p));
      send_pkt(-1, 1'b0);
    end
    idle(1);
    check("b2b_cnt", o_pkt_cnt, 9);
    check("b2b_err", o_err_cnt, 0);
    check("b2b_len_last", last_len, 128);

    // Data corruption on beat 5.
    build_pkt(16, 16'd128, 8'hFF);
    b_data[5] = 64'h0;
    send_pkt(-1, 1'b0);
    idle(1);
    check("data_ok", last_ok, 0);
    check("data_flags", o_err_flags, 4'b0001);
    check("data_errcnt", o_err_cnt, 1);

    // Illegal last tkeep, length otherwise consistent (15*8 + 2 bytes).
    build_pkt(16, 16'd122, 8'b1010_0000);
    send_pkt(-1, 1'b0);
    idle(1);
    check("keep_flags", o_err_flags, 4'b0101);
    check("keep_len", last_len, 122);

    // tuser short by one byte.
    build_pkt(16, 16'd127, 8'hFF);
    send_pkt(-1, 1'b0);
    idle(1);
    check("len_flags", o_err_flags, 4'b0111);
    check("len_errcnt", o_err_cnt, 3);

    // Standalone clear.
    i_clr_stats = 1'b1;
    @(negedge clk);
    i_clr_stats = 1'b0;
    idle(1);
    check("clr_cnt", o_pkt_cnt, 0);
    check("clr_flags", o_err_flags, 0);

    // Overlength: 300 full beats.
    done_base = n_done;
    build_pkt(300, 16'd2400, 8'hFF);
    send_pkt(-1, 1'b0);
    idle(1);
    check("over_dones", n_done - done_base, 1);
    check("over_ok", last_ok, 0);
    check("over_len", last_len, 2400);
    check("over_flags", o_err_flags, 4'b1000);

    // Backpressure pattern, then a packet through it.
    i_bp_en = 1'b1;
    idle(3);
    for (int i = 0; i < 8; i++) begin
      rs[i] = s_axis_tready;
      @(negedge clk);
    end
    z = 0;
    for (int i = 3; i >= 0; i--) if (!rs[i]) z = i;
    rs_exp = ~(8'h11 << z);
    check("bp_pattern", rs, rs_exp);
    build_pkt(16, 16'd128, 8'hFF);
    send_pkt(-1, 1'b0);
    i_bp_en = 1'b0;
    idle(1);
    check("bp_ok", last_ok, 1);
    check("bp_len", last_len, 128);
    check("bp_cnt", o_pkt_cnt, 2);

    // Clear coinciding with a completion.
    done_base = n_done;
    build_pkt(16, 16'd128, 8'hFF);
    send_pkt(-1, 1'b1);
    idle(1);
    check("clrcol_done", n_done - done_base, 1);
    check("clrcol_cnt", o_pkt_cnt, 0);
    check("clrcol_err", o_err_cnt, 0);
    check("clrcol_flags", o_err_flags, 0);

    // Reset during beat 7, then a clean packet.
    done_base = n_done;
    build_pkt(16, 16'd128, 8'hFF);
    send_pkt(7, 1'b0);
    idle(2);
    check("rstmid_nodone", n_done - done_base, 0);
    send_pkt(-1, 1'b0);
    idle(1);
    check("rstmid_done", n_done - done_base, 1);
    check("rstmid_ok", last_ok, 1);
    check("rstmid_cnt", o_pkt_cnt, 1);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
